// File: rtl/weight_ram_loader_pkg.sv
// rtl/weight_ram_loader_pkg.sv - shared constants, log2 helper and loader state type
//
// Used by the weight RAM loader and by the weight RAM itself, so both agree on
// the default matrix geometry and on how address/counter widths are derived.
package weight_ram_loader_pkg;

    localparam int DEFAULT_NROW     = 16;
    localparam int DEFAULT_NCOL     = 16;
    localparam int DEFAULT_BITWIDTH = 18;

    // Ceiling log2; log2(1) is 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/weight_row_packer.sv
// rtl/weight_row_packer.sv - collects NROW words into one RAM row
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   clear         : restart the word counter at slot 0
//   word_in       : incoming weight word
//   word_take     : word_in is transferred this cycle
//   row_data      : packed row including the word transferred this cycle
//   row_complete  : this cycle's transfer fills the last slot of the row
module weight_row_packer
    import weight_ram_loader_pkg::*;
#(
    parameter int NROW     = DEFAULT_NROW,
    parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [BITWIDTH-1:0]      word_in,
    input  logic                     word_take,
    output logic [BITWIDTH*NROW-1:0] row_data,
    output logic                     row_complete
);

    localparam int CNT_W = log2(NROW) + 1;

    logic [CNT_W-1:0]         word_cnt;
    logic [BITWIDTH*NROW-1:0] row_q;

    // row_data already holds the current word so the loader can latch the
    // finished row on the same edge that accepts its last word.
    always_comb begin
        row_data = row_q;
        for (int k = 0; k < NROW; k++) begin
            if (word_take && (word_cnt == CNT_W'(k))) begin
                row_data[k*BITWIDTH +: BITWIDTH] = word_in;
            end
        end
    end

    assign row_complete = word_take && (word_cnt == CNT_W'(NROW - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
            row_q    <= '0;
        end else begin
            if (clear) begin
                word_cnt <= '0;
            end else if (word_take) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (word_take) begin
                row_q <= row_data;
            end
        end
    end

endmodule

// File: rtl/weight_ram_loader.sv
// rtl/weight_ram_loader.sv - streams weight words into the weight RAM row by row
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : begin loading a matrix (only honoured when idle)
//   wordIn, wordValid  : incoming weight word and its valid
//   wordReady          : word is accepted when wordValid && wordReady
//   ramAddress, ramRow : RAM write port address and row data
//   ramWriteEn         : RAM write enable (one cycle per completed row)
//   busy               : loader is not idle
//   done               : one-cycle pulse after the last row write
module weight_ram_loader
    import weight_ram_loader_pkg::*;
#(
    parameter int NROW          = DEFAULT_NROW,
    parameter int NCOL          = DEFAULT_NCOL,
    parameter int BITWIDTH      = DEFAULT_BITWIDTH,
    parameter int ADDR_BITWIDTH = log2(NCOL)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [BITWIDTH-1:0]      wordIn,
    input  logic                     wordValid,
    output logic                     wordReady,
    output logic [ADDR_BITWIDTH-1:0] ramAddress,
    output logic [BITWIDTH*NROW-1:0] ramRow,
    output logic                     ramWriteEn,
    output logic                     busy,
    output logic                     done
);

    loader_state_t state, state_next;

    logic [ADDR_BITWIDTH-1:0] col_cnt;
    logic                     word_take;
    logic                     row_complete;
    logic                     packer_clear;
    logic                     last_col;
    logic [BITWIDTH*NROW-1:0] row_packed;

    // wordReady is only ever high in FILL, so this is the transfer strobe.
    assign word_take    = wordValid && wordReady;
    assign last_col     = (col_cnt == ADDR_BITWIDTH'(NCOL - 1));
    assign packer_clear = ((state == ST_IDLE) && start) || (state == ST_WRITE);

    weight_row_packer #(
        .NROW     (NROW),
        .BITWIDTH (BITWIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (packer_clear),
        .word_in      (wordIn),
        .word_take    (word_take),
        .row_data     (row_packed),
        .row_complete (row_complete)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_FILL;
            ST_FILL:  if (row_complete) state_next = ST_WRITE;
            ST_WRITE: state_next = last_col ? ST_DONE : ST_FILL;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one is
    // valid for exactly the cycle spent in the corresponding state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            col_cnt    <= '0;
            wordReady  <= 1'b0;
            ramAddress <= '0;
            ramRow     <= '0;
            ramWriteEn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            wordReady  <= (state_next == ST_FILL);
            ramWriteEn <= (state_next == ST_WRITE);
            busy       <= (state_next != ST_IDLE);
            done       <= (state_next == ST_DONE);

            if ((state == ST_IDLE) && start) begin
                col_cnt <= '0;
            end else if ((state == ST_WRITE) && !last_col) begin
                col_cnt <= col_cnt + 1'b1;
            end

            // ramRow/ramAddress change only when a row completes and hold otherwise.
            if (row_complete) begin
                ramAddress <= col_cnt;
                ramRow     <= row_packed;
            end
        end
    end

endmodule

// File: tb/tb_weight_ram_loader.sv
// tb/tb_weight_ram_loader.sv - randomized self-checking bench for weight_ram_loader
module tb_weight_ram_loader;

    localparam int SN = 4;
    localparam int SC = 4;
    localparam int BW = 18;
    localparam int BN = 16;
    localparam int BC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // small instance (4x4)
    logic             s_reset, s_start, s_valid, s_ready, s_we, s_busy, s_done;
    logic [BW-1:0]    s_word;
    logic [1:0]       s_addr;
    logic [SN*BW-1:0] s_row;

    // default instance (16x16)
    logic             b_reset, b_start, b_valid, b_ready, b_we, b_busy, b_done;
    logic [BW-1:0]    b_word;
    logic [3:0]       b_addr;
    logic [BN*BW-1:0] b_row;

    weight_ram_loader #(.NROW(SN), .NCOL(SC), .BITWIDTH(BW)) dut_small (
        .clk        (clk),
        .reset      (s_reset),
        .start      (s_start),
        .wordIn     (s_word),
        .wordValid  (s_valid),
        .wordReady  (s_ready),
        .ramAddress (s_addr),
        .ramRow     (s_row),
        .ramWriteEn (s_we),
        .busy       (s_busy),
        .done       (s_done)
    );

    weight_ram_loader dut_big (
        .clk        (clk),
        .reset      (b_reset),
        .start      (b_start),
        .wordIn     (b_word),
        .wordValid  (b_valid),
        .wordReady  (b_ready),
        .ramAddress (b_addr),
        .ramRow     (b_row),
        .ramWriteEn (b_we),
        .busy       (b_busy),
        .done       (b_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference stimulus and RAM models
    logic [BW-1:0]    s_words [SN*SC];
    int               s_waddr [$];
    logic [SN*BW-1:0] s_wrow  [$];
    logic [SN*BW-1:0] mem_s   [SC];
    int               s_done_cnt = 0;
    int               s_rdy_wr   = 0;
    logic [BN*BW-1:0] mem_b   [BC];
    int               b_nwr      = 0;
    int               b_done_cnt = 0;

    // RAMs sample their write port on the falling edge.
    always @(negedge clk) begin
        if (s_we) begin
            s_waddr.push_back(int'(s_addr));
            s_wrow.push_back(s_row);
            mem_s[s_addr] <= s_row;
        end
        if (s_we && s_ready) s_rdy_wr <= s_rdy_wr + 1;
        if (s_done) s_done_cnt <= s_done_cnt + 1;
        if (b_we) begin
            mem_b[b_addr] <= b_row;
            b_nwr <= b_nwr + 1;
        end
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Row c of the matrix is words c*NROW .. c*NROW+NROW-1, first word in the low slot.
    function automatic logic [SN*BW-1:0] exp_row_s(input int c);
        logic [SN*BW-1:0] r;
        for (int k = 0; k < SN; k++) r[k*BW +: BW] = s_words[c*SN + k];
        return r;
    endfunction

    task automatic check_small_load(input int wb, input int db, input int rb);
        chk("s_nwrites", s_waddr.size() - wb, SC);
        for (int c = 0; c < SC; c++) begin
            if (wb + c < s_waddr.size()) begin
                chk("s_waddr", s_waddr[wb+c], c);
                chk("s_wrow", s_wrow[wb+c], exp_row_s(c));
            end
            chk("s_mem", mem_s[c], exp_row_s(c));
        end
        chk("s_done_cnt", s_done_cnt - db, 1);
        chk("s_ready_in_write", s_rdy_wr - rb, 0);
        chk("s_busy_after", s_busy, 1'b0);
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random valid
    task automatic run_small(input int mode, input bit poke, input int limit, input bit check_lat);
        int idx, budget, wb, db, rb, got, dcyc, sedge;
        idx = 0; budget = 0; got = 0; dcyc = 0;
        wb = s_waddr.size(); db = s_done_cnt; rb = s_rdy_wr;
        @(negedge clk);
        s_start = 1'b1;
        sedge = cyc + 1;
        while (idx < limit && budget < 1000) begin
            @(negedge clk);
            s_start = poke && (budget == 7);
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = (budget % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_word = s_words[idx];
            if (s_valid && s_ready) idx++;
            budget++;
        end
        chk("s_feed_timeout", idx, limit);
        @(negedge clk);
        s_valid = 1'b0;
        s_start = 1'b0;
        if (limit < SN*SC) return;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (s_done) begin
                got = 1;
                dcyc = cyc;
            end
        end
        chk("s_done_seen", got, 1);
        if (check_lat && got != 0) chk("s_latency", dcyc - sedge + 2, 1 + SC*(SN+1) + 1);
        @(negedge clk);
        check_small_load(wb, db, rb);
    endtask

    initial begin
        int wb, idx, budget, got;
        s_reset = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_word = '0;
        b_reset = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_word = '0;
        repeat (3) @(negedge clk);
        chk("rst_small", {s_ready, s_we, s_busy, s_done, s_addr, s_row}, '0);
        chk("rst_big", {b_ready, b_we, b_busy, b_done, b_addr, b_row}, '0);
        s_reset = 1'b0;
        b_reset = 1'b0;

        // valid while idle: nothing accepted, nothing written
        wb = s_waddr.size();
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_word = BW'($urandom);
            chk("idle_ready", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        chk("idle_nwrites", s_waddr.size() - wb, 0);

        // words 0..15, continuous valid
        for (int i = 0; i < SN*SC; i++) s_words[i] = BW'(i);
        run_small(0, 1'b0, SN*SC, 1'b1);
        chk("s_row0_literal", mem_s[0], {18'd3, 18'd2, 18'd1, 18'd0});

        // same words, valid toggling every other cycle
        run_small(1, 1'b0, SN*SC, 1'b0);

        // random words, random gaps, stray start pulse while busy
        for (int i = 0; i < SN*SC; i++) s_words[i] = BW'($urandom);
        run_small(2, 1'b1, SN*SC, 1'b0);

        // reset after six words: only row 0 may have been written
        for (int i = 0; i < SN*SC; i++) s_words[i] = BW'($urandom);
        wb = s_waddr.size();
        run_small(2, 1'b0, 6, 1'b0);
        s_reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_outs", {s_ready, s_we, s_busy, s_done, s_addr, s_row}, '0);
        s_reset = 1'b0;
        chk("mid_rst_nwrites", s_waddr.size() - wb, 1);
        if (s_waddr.size() > wb) chk("mid_rst_waddr", s_waddr[wb], 0);

        // fresh load after reset starts at address 0
        for (int i = 0; i < SN*SC; i++) s_words[i] = BW'($urandom);
        run_small(0, 1'b0, SN*SC, 1'b1);

        // default geometry, words equal to index, random valid gaps
        wb = b_done_cnt;
        @(negedge clk);
        b_start = 1'b1;
        idx = 0; budget = 0; got = 0;
        while (idx < BN*BC && budget < 5000) begin
            @(negedge clk);
            b_start = 1'b0;
            b_valid = ($urandom_range(0, 3) != 0);
            b_word = BW'(idx);
            if (b_valid && b_ready) idx++;
            budget++;
        end
        chk("b_feed_timeout", idx, BN*BC);
        @(negedge clk);
        b_valid = 1'b0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (b_done) got = 1;
        end
        chk("b_done_seen", got, 1);
        @(negedge clk);
        chk("b_nwrites", b_nwr, BC);
        chk("b_done_cnt", b_done_cnt - wb, 1);
        chk("b_busy_after", b_busy, 1'b0);
        for (int c = 0; c < BC; c++) begin
            for (int k = 0; k < BN; k++) begin
                chk("b_mem_word", mem_b[c][k*BW +: BW], BW'(BN*c + k));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/weight_ram_loader.md
# weight_ram_loader

Streaming writer for the weight RAM: accepts weights one word at a time over a valid/ready handshake, packs NROW consecutive words into one RAM row, and issues one write per completed row to column addresses 0..NCOL-1 in order. It sits between the training datapath or host weight source and the weight RAM's write port (address, row data, write enable). It loads a full NROW×NCOL matrix per `start`.

## Interface
- NROW, 16, words per RAM row; must match the RAM's NROW
- NCOL, 16, rows per matrix (RAM depth); power of two, ≥2
- BITWIDTH, 18, bits per weight word
- ADDR_BITWIDTH, log2(NCOL), derived; not overridden

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin loading a matrix; sampled only in IDLE
- wordIn  in  BITWIDTH  weight word
- wordValid  in  1  wordIn is valid
- wordReady  out  1  loader accepts wordIn this cycle
- ramAddress  out  ADDR_BITWIDTH  drives RAM write address
- ramRow  out  BITWIDTH*NROW  drives RAM row input
- ramWriteEn  out  1  drives RAM write enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last row write

## Operation
- All outputs are registered. Reset values: wordReady=0, ramAddress=0, ramRow=0, ramWriteEn=0, busy=0, done=0. State is IDLE. Word and column counters are 0.
- A word transfers on a cycle where wordValid && wordReady.
- Packing order: the k-th accepted word of a row (k=0..NROW-1) is placed at ramRow[k*BITWIDTH +: BITWIDTH].
- Row c (c=0..NCOL-1) is written to ramAddress=c.
- FSM states:
  - IDLE: wordReady=0. On start=1, clear counters, set busy, go to FILL.
  - FILL: wordReady=1. Each transfer stores the word and increments wordCnt. The transfer with wordCnt==NROW-1 goes to WRITE and drops wordReady on the next cycle.
  - WRITE: exactly one cycle. ramWriteEn=1, ramAddress=colCnt, ramRow=packed row, wordReady=0. If colCnt==NCOL-1, go to DONE. Otherwise colCnt+1, wordCnt=0, go to FILL.
  - DONE: done=1 for one cycle, busy=0 on exit, go to IDLE.
- wordValid gaps in FILL stall the loader indefinitely. There is no timeout.
- start outside IDLE is ignored. wordValid outside FILL is ignored, and no word is consumed.
- ramRow holds its last value between writes. It is only meaningful while ramWriteEn=1.
- Reset mid-operation (any state) returns to IDLE with reset values on the next edge. The partial row is discarded and no write is issued. Previously written RAM rows are not touched.
- Counter widths: wordCnt is log2(NROW)+1 bits, colCnt is ADDR_BITWIDTH bits. Neither counter wraps within one load.

## Timing
- The loader drives on posedge clk. The RAM samples its write port on negedge clk, so each write gets a half-cycle of setup.
- ramWriteEn is high in the cycle immediately after the edge that accepted word NROW-1 of the row.
- Minimum load time with continuous valid: 1 (start) + NCOL*(NROW+1) + 1 (DONE) cycles.
- With continuous valid, wordReady is high for NROW consecutive cycles per row, then low for 1 cycle (WRITE).
- done pulses the cycle after the final ramWriteEn. busy falls together with done going low.

## Structure
- Shared include/package: the log2 function and the default NROW/NCOL/BITWIDTH constants. These are used by both this block and the weight RAM.
- One sub-module is natural: weight_row_packer. It holds the word counter and the shift/insert register, and reports row-complete.
- The FSM and column counter stay in weight_ram_loader.

## Test plan
- NROW=4, NCOL=4, BITWIDTH=18; start, then words 0..15 with continuous valid.
  - Required: ramWriteEn exactly 4 times, at addresses 0,1,2,3.
  - Row 0 is {18'd3,18'd2,18'd1,18'd0}.
  - done fires 22 cycles after start is sampled.
- Same load with wordValid toggling every other cycle. Required: identical RAM contents, no extra or missing writes, wordReady never high in WRITE.
- Assert reset after 6 words accepted (row 1 partially filled). Required:
  - all outputs are 0 on the next cycle;
  - only the row-0 write occurred;
  - a subsequent start reloads from address 0.
- Pulse start again while busy. Required: ignored, with counters and addresses unaffected.
- Default parameters (16×16×18), with words equal to index and a RAM model attached.
  - Required: reading back address c yields words 16c..16c+15.
  - done pulses once.
  - busy is low afterwards.
- Apply wordValid=1 in IDLE with no start. Required: wordReady stays 0 and no RAM write occurs.
